// File: rtl/fb_arbiter_if.sv
// Client and framebuffer signal bundle for fb_arbiter.
// master: the arbiter side; slave: the clients/framebuffer side.
interface fb_arbiter_if;
   logic       d_req;
   logic       d_mode;
   logic [7:0] d_xpos;
   logic [7:0] d_ypos;
   logic       d_grant;
   logic       d_valid;
   logic [7:0] d_dout;

   logic       w_req;
   logic [7:0] w_xpos;
   logic [7:0] w_ypos;
   logic [7:0] w_din;
   logic       w_grant;
   logic       w_done;

   logic [7:0] fb_xpos;
   logic [7:0] fb_ypos;
   logic       fb_mode;
   logic [7:0] fb_din;
   logic       fb_re;
   logic       fb_we;
   logic [7:0] fb_dout;
   logic       fb_data_valid;
   logic       fb_busy;

   logic       err;

   modport master (
      input  d_req, d_mode, d_xpos, d_ypos,
      input  w_req, w_xpos, w_ypos, w_din,
      input  fb_dout, fb_data_valid, fb_busy,
      output d_grant, d_valid, d_dout,
      output w_grant, w_done,
      output fb_xpos, fb_ypos, fb_mode, fb_din, fb_re, fb_we,
      output err
   );

   modport slave (
      output d_req, d_mode, d_xpos, d_ypos,
      output w_req, w_xpos, w_ypos, w_din,
      output fb_dout, fb_data_valid, fb_busy,
      input  d_grant, d_valid, d_dout,
      input  w_grant, w_done,
      input  fb_xpos, fb_ypos, fb_mode, fb_din, fb_re, fb_we,
      input  err
   );
endinterface

// File: rtl/fb_arbiter.sv
// Round-robin arbiter sharing one framebuffer port between display reads and draw writes.
// Define FB_ARB_TIMEOUT_EN to enable the wait-state watchdog and sticky err flag.
module fb_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   fb_arbiter_if.master  bus
);

   typedef enum logic [2:0] {IDLE, RD_SETUP, RD_WAIT, WR_SETUP, WR_WAIT} state_t;

   state_t     state_q;
   logic       d_grant_q;
   logic       d_valid_q;
   logic [7:0] d_dout_q;
   logic       w_grant_q;
   logic       w_done_q;
   logic [7:0] fb_xpos_q;
   logic [7:0] fb_ypos_q;
   logic       fb_mode_q;
   logic [7:0] fb_din_q;
   logic       fb_re_q;
   logic       fb_we_q;
   logic       prefer_d_q;
   logic       wr_skip_q;

   logic       pick_d_d;
   logic       pick_w_d;
   logic       rd_hit_d;
   logic       wr_hit_d;
   logic       abort_d;

   // RD_WAIT with fb_re low means the byte is already captured.
   assign rd_hit_d = (state_q == RD_WAIT) && fb_re_q && bus.fb_data_valid;
   assign wr_hit_d = (state_q == WR_WAIT) && !wr_skip_q && !bus.fb_busy;

`ifdef FB_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WD_W-1:0] wd_q;
   logic            wd_run_d;
   logic            err_q;

   assign wd_run_d = ((state_q == RD_WAIT) && fb_re_q) || (state_q == WR_WAIT);
   assign abort_d  = wd_run_d && (32'(wd_q) == TIMEOUT - 1) && !rd_hit_d && !wr_hit_d;

   always_ff @(posedge clk) begin
      if (reset || !wd_run_d || abort_d) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (abort_d) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_timeout;

   assign abort_d        = 1'b0;
   assign unused_timeout = ^TIMEOUT;
   assign bus.err        = 1'b0;
`endif

   always_comb begin
      pick_d_d = 1'b0;
      pick_w_d = 1'b0;
      if (!bus.fb_busy) begin
         if (bus.d_req && (!bus.w_req || prefer_d_q)) begin
            pick_d_d = 1'b1;
         end else if (bus.w_req) begin
            pick_w_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         d_grant_q  <= 1'b0;
         d_valid_q  <= 1'b0;
         d_dout_q   <= '0;
         w_grant_q  <= 1'b0;
         w_done_q   <= 1'b0;
         fb_xpos_q  <= '0;
         fb_ypos_q  <= '0;
         fb_mode_q  <= 1'b0;
         fb_din_q   <= '0;
         fb_re_q    <= 1'b0;
         fb_we_q    <= 1'b0;
         prefer_d_q <= 1'b1;
         wr_skip_q  <= 1'b0;
      end else begin
         d_valid_q <= 1'b0;
         w_done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_d_d) begin
                  d_grant_q  <= 1'b1;
                  fb_xpos_q  <= bus.d_xpos;
                  fb_ypos_q  <= bus.d_ypos;
                  fb_mode_q  <= bus.d_mode;
                  prefer_d_q <= 1'b0;
                  state_q    <= RD_SETUP;
               end else if (pick_w_d) begin
                  w_grant_q  <= 1'b1;
                  fb_xpos_q  <= bus.w_xpos;
                  fb_ypos_q  <= bus.w_ypos;
                  fb_mode_q  <= 1'b0;
                  fb_din_q   <= bus.w_din;
                  prefer_d_q <= 1'b1;
                  state_q    <= WR_SETUP;
               end
            end
            RD_SETUP: begin
               fb_re_q <= 1'b1;
               state_q <= RD_WAIT;
            end
            RD_WAIT: begin
               if (!fb_re_q) begin
                  d_valid_q <= 1'b1;
                  d_grant_q <= 1'b0;
                  state_q   <= IDLE;
               end else if (rd_hit_d) begin
                  d_dout_q <= bus.fb_dout;
                  fb_re_q  <= 1'b0;
               end else if (abort_d) begin
                  fb_re_q   <= 1'b0;
                  d_grant_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            // The fb_we pulse is the second WR_SETUP cycle.
            WR_SETUP: begin
               if (!fb_we_q) begin
                  fb_we_q <= 1'b1;
               end else begin
                  fb_we_q   <= 1'b0;
                  wr_skip_q <= 1'b1;
                  state_q   <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               wr_skip_q <= 1'b0;
               if (wr_hit_d) begin
                  w_done_q  <= 1'b1;
                  w_grant_q <= 1'b0;
                  state_q   <= IDLE;
               end else if (abort_d) begin
                  w_grant_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.d_grant = d_grant_q;
   assign bus.d_valid = d_valid_q;
   assign bus.d_dout  = d_dout_q;
   assign bus.w_grant = w_grant_q;
   assign bus.w_done  = w_done_q;
   assign bus.fb_xpos = fb_xpos_q;
   assign bus.fb_ypos = fb_ypos_q;
   assign bus.fb_mode = fb_mode_q;
   assign bus.fb_din  = fb_din_q;
   assign bus.fb_re   = fb_re_q;
   assign bus.fb_we   = fb_we_q;

endmodule
